// File: rtl/uart_sched_pkg.sv
// Shared types and constants for the UART transmit scheduler.
// Byte timing assumes a transmitter that needs tx_bits+3 cycles per byte.
package uart_sched_pkg;

    typedef enum logic [2:0] {
        ST_HOLDOFF = 3'd0,
        ST_IDLE    = 3'd1,
        ST_START   = 3'd2,
        ST_WAIT    = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    localparam logic [3:0] HDR_TAG_DEFAULT  = 4'hA;
    localparam int         UART_BYTE_BITS   = 8;
    localparam int         UART_BYTE_PERIOD = UART_BYTE_BITS + 3;

    // Index width that stays legal for a single requester.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after last_grant+1,
// wrapping around.
module rr_arbiter
    import uart_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any
);

    int                 base;
    logic [NUM_REQ-1:0] rot;
    logic               found;

    always_comb begin
        base      = (int'(last_grant) + 1) % NUM_REQ;
        // Rotate so bit 0 is the highest-priority requester this round.
        rot       = NUM_REQ'({req, req} >> base);
        grant_idx = '0;
        found     = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && rot[i]) begin
                grant_idx = IDX_W'((base + i) % NUM_REQ);
                found     = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one UART transmitter among NUM_REQ producers: each grant sends a
// header byte {HDR_TAG, index} followed by the latched word, LSB byte first.
module uart_tx_sched
    import uart_sched_pkg::*;
#(
    parameter int         NUM_REQ    = 4,
    parameter int         WORD_BYTES = 4,
    parameter logic [3:0] HDR_TAG    = HDR_TAG_DEFAULT,
    parameter int         TIMEOUT    = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*WORD_BYTES*8-1:0] req_data,
    output logic [NUM_REQ-1:0]            ack,
    output logic [NUM_REQ-1:0]            err,
    output logic                          busy,
    output logic [7:0]                    tx_din,
    output logic [5:0]                    tx_bits,
    output logic                          tx_start,
    input  logic                          tx_done
);

    localparam int IDX_W  = idx_width(NUM_REQ);
    localparam int WORD_W = WORD_BYTES * 8;
    localparam int TO_W   = $clog2(TIMEOUT + 1);
    localparam int BI_W   = $clog2(WORD_BYTES + 1);
    localparam int HO_W   = $clog2(UART_BYTE_PERIOD);

    state_t             state;
    logic [IDX_W-1:0]   grant;
    logic [IDX_W-1:0]   last_grant;
    logic [IDX_W-1:0]   pick;
    logic               pick_any;
    logic [WORD_W-1:0]  shadow;
    logic [BI_W-1:0]    byte_idx;
    logic [TO_W-1:0]    to_cnt;
    logic [HO_W-1:0]    ho_cnt;
    logic [7:0]         next_byte;
    logic [NUM_REQ-1:0] grant_1h;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req        (req),
        .last_grant (last_grant),
        .grant_idx  (pick),
        .any        (pick_any)
    );

    // Payload byte k (k>=1) is shadow byte k-1, i.e. shadow byte byte_idx
    // when advancing from byte byte_idx.
    assign next_byte = 8'(shadow >> {byte_idx, 3'b000});
    assign grant_1h  = NUM_REQ'(1) << grant;
    assign busy      = (state != ST_IDLE);
    assign tx_bits   = 6'(UART_BYTE_BITS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_HOLDOFF;
            ho_cnt     <= '0;
            grant      <= '0;
            last_grant <= IDX_W'(NUM_REQ - 1);
            shadow     <= '0;
            byte_idx   <= '0;
            to_cnt     <= '0;
            tx_din     <= 8'h00;
            tx_start   <= 1'b0;
            ack        <= '0;
            err        <= '0;
        end else begin
            tx_start <= 1'b0;
            ack      <= '0;
            err      <= '0;
            case (state)
                ST_HOLDOFF: begin
                    // Let any byte still in the transmitter drain; tx_done ignored.
                    if (ho_cnt == HO_W'(UART_BYTE_PERIOD - 1)) begin
                        ho_cnt <= '0;
                        state  <= ST_IDLE;
                    end else begin
                        ho_cnt <= ho_cnt + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (pick_any) begin
                        grant    <= pick;
                        shadow   <= WORD_W'(req_data >> (int'(pick) * WORD_W));
                        byte_idx <= '0;
                        tx_din   <= {HDR_TAG, 4'(pick)};
                        tx_start <= 1'b1;
                        state    <= ST_START;
                    end
                end
                ST_START: begin
                    to_cnt <= '0;
                    state  <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (tx_done) begin
                        if (byte_idx == BI_W'(WORD_BYTES)) begin
                            ack   <= grant_1h;
                            state <= ST_DONE;
                        end else begin
                            byte_idx <= byte_idx + 1'b1;
                            tx_din   <= next_byte;
                            tx_start <= 1'b1;
                            state    <= ST_START;
                        end
                    end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
                        err    <= grant_1h;
                        ho_cnt <= '0;
                        state  <= ST_HOLDOFF;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    last_grant <= grant;
                    state      <= ST_IDLE;
                end
                default: state <= ST_HOLDOFF;
            endcase
        end
    end

endmodule
